gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Parametrised GCD engine; successor to the fixed 4-bit FSM+datapath GCD unit.
- Generalised to WIDTH-bit operands, with a per-operation mode select:
  - subtractive Euclid (mode 0);
  - binary/Stein (mode 1).
- Handles zero operands, uses a Start/Busy/Done handshake, and reports an iteration count.
- Sits as a compute slave beside the board-level control logic.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CW, 8, width of the ITER_CNT counter (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Mode  input  1  0 = subtractive, 1 = binary; latched with Start.
- X_in  input  WIDTH  operand X; latched with Start.
- Y_in  input  WIDTH  operand Y; latched with Start.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when GCD_out is valid.
- GCD_out  output  WIDTH  result; held until the next result is written.
- ITER_CNT  output  CW  RUN cycles used by the last operation, saturating at 2^CW-1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; x, y, k, GCD_out, ITER_CNT, Busy, Done all 0; mode register 0. A reset mid-operation aborts it with no Done.
- Internal registers:
  - x, y: WIDTH bits.
  - k: shift count, ceil(log2(WIDTH+1)) bits.
  - md: latched mode.
  - cnt: CW bits.
- States: IDLE, RUN.
- Done defaults to 0 every cycle; it is a single-cycle pulse only.
- IDLE, Start=1 at a clock edge:
  - If X_in==0 or Y_in==0: GCD_out<=X_in|Y_in, ITER_CNT<=0, Done<=1, stay IDLE. gcd(0,0)=0.
  - Otherwise: x<=X_in, y<=Y_in, md<=Mode, k<=0, cnt<=0, Busy<=1, state<=RUN.
- IDLE, Start=0: hold all registers.
- RUN, every cycle: cnt increments (saturating at all-ones).
- RUN, termination: when x==y, then GCD_out<=x<<k (truncated to WIDTH; it cannot overflow), ITER_CNT<=cnt+1 (saturating), Done<=1, Busy<=0, state<=IDLE.
- RUN, md=0 (subtractive), when x!=y:
  - x<y: y<=y-x.
  - x>y: x<=x-y.
- RUN, md=1 (binary), when x!=y, first matching rule applies:
  - x and y both even: x<=x>>1, y<=y>>1, k<=k+1.
  - x even: x<=x>>1.
  - y even: y<=y>>1.
  - both odd, x>y: x<=(x-y)>>1.
  - both odd, x<y: y<=(y-x)>>1.
- Invariants and handshake:
  - Operands stay nonzero in RUN, so the loop always terminates.
  - Start, Mode, X_in and Y_in are ignored while Busy=1; no queueing.
  - Start held high continuously issues back-to-back operations, one per IDLE cycle. The cycle after Done is IDLE.
- Latency:
  - From the Start edge to the Done edge = ITER_CNT cycles. The Done pulse is visible in the cycle after the final RUN edge.
  - Zero-operand case: Done in the cycle after the Start edge.
- Subtractive worst case is 2^WIDTH-1 RUN cycles; binary worst case is <= 2*WIDTH+1.
- Arithmetic:
  - All subtractions are unsigned WIDTH-bit. The operand order guarantees no underflow.
  - The x==y, x<y and even/odd compares use the registered x and y only.

Test Plan:
- Mode=0, X=12, Y=8, Start pulse -> 3 RUN cycles, Done pulse with GCD_out=4, ITER_CNT=3, Busy high for exactly 3 cycles.
- Mode=1, X=12, Y=8 -> GCD_out=4, ITER_CNT=5 (k=2 common shifts), Done one cycle wide.
- WIDTH=8, X=255, Y=1:
  - Mode=0 -> GCD_out=1, ITER_CNT=255.
  - Mode=1 -> GCD_out=1, ITER_CNT=8.
- Zero cases:
  - X=0, Y=9 -> GCD_out=9, ITER_CNT=0, Done the cycle after Start, Busy never high.
  - X=0, Y=0 -> GCD_out=0.
  - X=7, Y=7 -> GCD_out=7, ITER_CNT=1.
- Mid-operation behaviour:
  - Start Mode=0 with X=200, Y=3.
  - Toggle Start, Mode, X_in and Y_in during RUN -> inputs ignored, result 1.
  - Repeat the operation and assert reset low mid-RUN -> Busy, Done, GCD_out and ITER_CNT go 0 immediately, with no Done pulse.
- Random sweep, both modes, WIDTH=8 and WIDTH=4, against a reference gcd model:
  - GCD_out matches the model.
  - Exactly one Done per accepted Start.
  - Mode 1 ITER_CNT <= 2*WIDTH+1.

Source files
------------

// File: rtl/gcd_engine.sv
// WIDTH-bit GCD engine with a subtractive Euclid mode and a binary (Stein) mode.
// It uses a Start/Busy/Done handshake and reports the RUN cycles each operation took.
module gcd_engine #(
   parameter int WIDTH = 8,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             Mode,
   input  logic [WIDTH-1:0] X_in,
   input  logic [WIDTH-1:0] Y_in,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] GCD_out,
   output logic [CW-1:0]    ITER_CNT,
   output logic             dbg_state_o
);

   localparam int KW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, gcd_q, gcd_d;
   logic [KW-1:0]    k_q, k_d;
   logic             md_q, md_d;
   logic [CW-1:0]    cnt_q, cnt_d, iter_q, iter_d, cnt_sat;
   logic             busy_q, busy_d, done_q, done_d;

   // The count saturates so that long subtractive runs report all-ones, not a wrapped value.
   assign cnt_sat = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         k_q     <= '0;
         md_q    <= 1'b0;
         cnt_q   <= '0;
         gcd_q   <= '0;
         iter_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         k_q     <= k_d;
         md_q    <= md_d;
         cnt_q   <= cnt_d;
         gcd_q   <= gcd_d;
         iter_q  <= iter_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      md_d    = md_q;
      cnt_d   = cnt_q;
      gcd_d   = gcd_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               // A zero operand would never terminate the loop; its answer is the other operand.
               if (X_in == '0 || Y_in == '0) begin
                  gcd_d  = X_in | Y_in;
                  iter_d = '0;
                  done_d = 1'b1;
               end else begin
                  x_d     = X_in;
                  y_d     = Y_in;
                  md_d    = Mode;
                  k_d     = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_sat;
            if (x_q == y_q) begin
               gcd_d   = x_q << k_q;
               iter_d  = cnt_sat;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (!md_q) begin
               if (x_q < y_q) y_d = y_q - x_q;
               else           x_d = x_q - y_q;
            end else begin
               // In binary mode, k counts the common factors of two that are restored at the end.
               if (!x_q[0] && !y_q[0]) begin
                  x_d = x_q >> 1;
                  y_d = y_q >> 1;
                  k_d = k_q + 1'b1;
               end else if (!x_q[0]) begin
                  x_d = x_q >> 1;
               end else if (!y_q[0]) begin
                  y_d = y_q >> 1;
               end else if (x_q > y_q) begin
                  x_d = (x_q - y_q) >> 1;
               end else begin
                  y_d = (y_q - x_q) >> 1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Busy        = busy_q;
   assign Done        = done_q;
   assign GCD_out     = gcd_q;
   assign ITER_CNT    = iter_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: an 8-bit instance and a 4-bit instance,
// with hand-computed vectors and a reference gcd for the sweep.
module tb_gcd_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start8 = 1'b0, mode8 = 1'b0;
   logic [7:0] x8 = '0, y8 = '0;
   logic       busy8, done8, st8;
   logic [7:0] gcd8, iter8;

   logic       start4 = 1'b0, mode4 = 1'b0;
   logic [3:0] x4 = '0, y4 = '0;
   logic       busy4, done4, st4;
   logic [3:0] gcd4;
   logic [7:0] iter4;

   logic       sel4 = 1'b0;
   logic       sel_done, sel_busy;
   logic [7:0] sel_gcd, sel_iter;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gcd_engine #(.WIDTH(8), .CW(8)) u_dut8 (
      .clk(clk), .reset(reset), .Start(start8), .Mode(mode8), .X_in(x8), .Y_in(y8),
      .Busy(busy8), .Done(done8), .GCD_out(gcd8), .ITER_CNT(iter8), .dbg_state_o(st8)
   );

   gcd_engine #(.WIDTH(4), .CW(8)) u_dut4 (
      .clk(clk), .reset(reset), .Start(start4), .Mode(mode4), .X_in(x4), .Y_in(y4),
      .Busy(busy4), .Done(done4), .GCD_out(gcd4), .ITER_CNT(iter4), .dbg_state_o(st4)
   );

   assign sel_done = sel4 ? done4 : done8;
   assign sel_busy = sel4 ? busy4 : busy8;
   assign sel_gcd  = sel4 ? {4'b0, gcd4} : gcd8;
   assign sel_iter = sel4 ? iter4 : iter8;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_gcd(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Issues one Start pulse and waits for Done; lat counts edges after the Start edge.
   task automatic run_op(input bit w4, input logic m, input logic [7:0] xa, input logic [7:0] ya,
                         output logic [7:0] g, output logic [7:0] it, output int lat,
                         output int busy_n, output bit pulse_ok, output bit tmo);
      bit busy_at_done;
      sel4 = w4;
      @(negedge clk);
      if (w4) begin
         start4 = 1'b1; mode4 = m; x4 = xa[3:0]; y4 = ya[3:0];
      end else begin
         start8 = 1'b1; mode8 = m; x8 = xa; y8 = ya;
      end
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
      lat = 0;
      busy_n = 0;
      while (!sel_done && lat < 600) begin
         if (sel_busy) busy_n++;
         @(negedge clk);
         lat++;
      end
      tmo = !sel_done;
      g = sel_gcd;
      it = sel_iter;
      busy_at_done = sel_busy;
      @(negedge clk);
      pulse_ok = !busy_at_done && !sel_done;
   endtask

   initial begin
      logic [7:0] g, it, xa, ya;
      int lat, busy_n, n, wmax;
      bit pulse_ok, tmo, seen, mm;

      repeat (2) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_gcd", gcd8, 0);
      check("rst_iter", iter8, 0);
      reset = 1'b1;

      run_op(0, 0, 8'd12, 8'd8, g, it, lat, busy_n, pulse_ok, tmo);
      check("m0_12_8_tmo", tmo, 0);
      check("m0_12_8_gcd", g, 4);
      check("m0_12_8_iter", it, 3);
      check("m0_12_8_lat", lat, 3);
      check("m0_12_8_busy", busy_n, 3);
      check("m0_12_8_pulse", pulse_ok, 1);

      run_op(0, 1, 8'd12, 8'd8, g, it, lat, busy_n, pulse_ok, tmo);
      check("m1_12_8_gcd", g, 4);
      check("m1_12_8_iter", it, 5);
      check("m1_12_8_lat", lat, 5);
      check("m1_12_8_pulse", pulse_ok, 1);

      run_op(0, 0, 8'd255, 8'd1, g, it, lat, busy_n, pulse_ok, tmo);
      check("m0_255_1_gcd", g, 1);
      check("m0_255_1_iter", it, 255);
      check("m0_255_1_lat", lat, 255);

      run_op(0, 1, 8'd255, 8'd1, g, it, lat, busy_n, pulse_ok, tmo);
      check("m1_255_1_gcd", g, 1);
      check("m1_255_1_iter", it, 8);

      run_op(0, 0, 8'd0, 8'd9, g, it, lat, busy_n, pulse_ok, tmo);
      check("z_0_9_gcd", g, 9);
      check("z_0_9_iter", it, 0);
      check("z_0_9_lat", lat, 0);
      check("z_0_9_busy", busy_n, 0);
      check("z_0_9_pulse", pulse_ok, 1);

      run_op(0, 1, 8'd0, 8'd0, g, it, lat, busy_n, pulse_ok, tmo);
      check("z_0_0_gcd", g, 0);
      check("z_0_0_lat", lat, 0);

      run_op(0, 0, 8'd7, 8'd7, g, it, lat, busy_n, pulse_ok, tmo);
      check("eq_7_7_gcd", g, 7);
      check("eq_7_7_iter", it, 1);
      check("eq_7_7_busy", busy_n, 1);

      // Inputs wiggling during RUN must not disturb gcd(200,3): 66+1+1 steps plus the final compare.
      sel4 = 1'b0;
      @(negedge clk);
      start8 = 1'b1; mode8 = 1'b0; x8 = 8'd200; y8 = 8'd3;
      @(negedge clk);
      start8 = 1'b0;
      repeat (5) @(negedge clk);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         start8 = i[0];
         mode8  = ~i[0];
         x8 = 8'($urandom_range(0, 255));
         y8 = 8'($urandom_range(0, 255));
         @(negedge clk);
         if (!busy8 || done8) seen = 1'b1;
      end
      start8 = 1'b0;
      check("ign_busy_held", seen, 0);
      n = 0;
      while (!done8 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ign_done_seen", done8, 1);
      check("ign_gcd", gcd8, 1);
      check("ign_iter", iter8, 69);
      @(negedge clk);

      @(negedge clk);
      start8 = 1'b1; mode8 = 1'b0; x8 = 8'd200; y8 = 8'd3;
      @(negedge clk);
      start8 = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_busy_before", busy8, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", busy8, 0);
      check("mid_rst_done", done8, 0);
      check("mid_rst_gcd", gcd8, 0);
      check("mid_rst_iter", iter8, 0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (done8 || busy8) seen = 1'b1;
      end
      check("mid_no_done", seen, 0);

      for (int w = 0; w < 2; w++) begin
         wmax = (w == 1) ? 4 : 8;
         for (int i = 0; i < 16; i++) begin
            mm = i[0];
            xa = 8'($urandom_range(0, (1 << wmax) - 1));
            ya = 8'($urandom_range(0, (1 << wmax) - 1));
            run_op(w[0], mm, xa, ya, g, it, lat, busy_n, pulse_ok, tmo);
            check("sweep_gcd", g, ref_gcd(int'(xa), int'(ya)));
            check("sweep_pulse", pulse_ok && !tmo, 1);
            if (mm) check("sweep_m1_bound", (int'(it) <= 2 * wmax + 1), 1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
